epp_regfile_v2: RTL and testbench



---
 rtl/epp_pkg.sv | 26 ++
 rtl/epp_sync.sv | 26 ++
 rtl/epp_regfile_v2.sv | 171 +++++++++++++++++
 tb/tb_epp_regfile_v2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/epp_pkg.sv
// Shared constants and types for the EPP register-file front end.
package epp_pkg;

    // Command/status addresses are these offsets above the general registers.
    localparam int OFS_BLIT   = 0;
    localparam int OFS_FILL   = 1;
    localparam int OFS_DMA    = 2;
    localparam int OFS_STATUS = 3;
    localparam int OFS_CTRL   = 4;

    localparam int ST_BUSY        = 0;
    localparam int ST_ERR_ADDR    = 1;
    localparam int ST_ERR_BUSY    = 2;
    localparam int ST_ERR_TIMEOUT = 3;

    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_CLR     = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RAM_WAIT = 2'd2,
        ACK      = 2'd3
    } epp_state_t;

endpackage

// File: rtl/epp_sync.sv
// Multi-stage flop chain bringing asynchronous host strobes into the clk domain.
module epp_sync #(
    parameter int             W         = 1,
    parameter int             STAGES    = 2,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/epp_regfile_v2.sv
// EPP slave: register file, blit/fill commands, RAM byte DMA and sticky status.
// Host handshake: each strobe-low access is answered by EppWait=1, released after both strobes return high.
module epp_regfile_v2
    import epp_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int RAM_TIMEOUT = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EppAstb,
    input  logic                  EppDstb,
    input  logic                  EppWR,
    output logic                  EppWait,
    inout  wire  [7:0]            EppDB,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  start_blit,
    output logic                  start_fill,
    output logic                  fill_value,
    output logic                  start_read_ram,
    output logic                  start_write_ram,
    output logic [7:0]            write_ram_byte,
    input  logic                  status,
    input  logic                  ram_byte_ready,
    input  logic [7:0]            ram_byte,
    output epp_state_t            state
);

    localparam int         TW       = $clog2(RAM_TIMEOUT + 1);
    localparam logic [7:0] A_LAST   = 8'(NUM_REGS - 1);
    localparam logic [7:0] A_BLIT   = 8'(NUM_REGS + OFS_BLIT);
    localparam logic [7:0] A_FILL   = 8'(NUM_REGS + OFS_FILL);
    localparam logic [7:0] A_DMA    = 8'(NUM_REGS + OFS_DMA);
    localparam logic [7:0] A_STATUS = 8'(NUM_REGS + OFS_STATUS);
    localparam logic [7:0] A_CTRL   = 8'(NUM_REGS + OFS_CTRL);

    logic          astb_s, dstb_s, wr_s;
    logic [7:0]    addr, addr_next, bus_q, reg_rd, status_byte;
    logic [6:0]    ctrl;
    logic          err_addr, err_busy, err_timeout, is_addr, is_reg;
    logic [TW-1:0] timer;

    // Idle levels: strobes released, WR in read direction.
    epp_sync #(.W(3), .STAGES(SYNC_STAGES), .RESET_VAL(3'b111)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({EppAstb, EppDstb, EppWR}),
        .q   ({astb_s, dstb_s, wr_s})
    );

    assign EppDB = wr_s ? bus_q : 8'bz;

    always_comb begin
        reg_rd = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (addr == 8'(k)) reg_rd = regs_flat[k*8 +: 8];
        status_byte                 = '0;
        status_byte[ST_BUSY]        = status;
        status_byte[ST_ERR_ADDR]    = err_addr;
        status_byte[ST_ERR_BUSY]    = err_busy;
        status_byte[ST_ERR_TIMEOUT] = err_timeout;
        is_reg    = (addr < A_BLIT);
        addr_next = (addr == A_LAST) ? 8'd0 : addr + 8'd1;
    end

    always_ff @(posedge clk) begin
        start_blit      <= 1'b0;
        start_fill      <= 1'b0;
        start_read_ram  <= 1'b0;
        start_write_ram <= 1'b0;
        if (rst) begin
            state          <= IDLE;
            EppWait        <= 1'b0;
            regs_flat      <= '0;
            addr           <= '0;
            ctrl           <= '0;
            bus_q          <= '0;
            err_addr       <= 1'b0;
            err_busy       <= 1'b0;
            err_timeout    <= 1'b0;
            write_ram_byte <= '0;
            fill_value     <= 1'b0;
            is_addr        <= 1'b0;
            timer          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!astb_s) begin
                        is_addr <= 1'b1;
                        state   <= ACCESS;
                    end else if (!dstb_s) begin
                        is_addr <= 1'b0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state   <= ACK;
                    EppWait <= 1'b1;
                    if (is_addr) begin
                        if (wr_s) bus_q <= addr;
                        else      addr  <= EppDB;
                    end else if (is_reg) begin
                        if (wr_s) bus_q <= reg_rd;
                        else
                            for (int k = 0; k < NUM_REGS; k++)
                                if (addr == 8'(k)) regs_flat[k*8 +: 8] <= EppDB;
                        if (ctrl[CTRL_AUTOINC]) addr <= addr_next;
                    end else if (addr == A_BLIT && !wr_s) begin
                        start_blit <= 1'b1;
                    end else if (addr == A_FILL && !wr_s) begin
                        start_fill <= 1'b1;
                        fill_value <= EppDB[0];
                    end else if (addr == A_DMA) begin
                        // A busy engine refuses DMA but the host still gets its ack.
                        if (status) begin
                            err_busy <= 1'b1;
                            if (wr_s) bus_q <= '0;
                        end else if (wr_s) begin
                            start_read_ram <= 1'b1;
                            timer          <= TW'(RAM_TIMEOUT);
                            state          <= RAM_WAIT;
                            EppWait        <= 1'b0;
                        end else begin
                            start_write_ram <= 1'b1;
                            write_ram_byte  <= EppDB;
                        end
                    end else if (addr == A_STATUS && wr_s) begin
                        bus_q <= status_byte;
                    end else if (addr == A_CTRL) begin
                        if (wr_s) begin
                            bus_q <= {1'b0, ctrl};
                        end else begin
                            ctrl <= EppDB[6:0];
                            if (EppDB[CTRL_CLR]) begin
                                err_addr    <= 1'b0;
                                err_busy    <= 1'b0;
                                err_timeout <= 1'b0;
                            end
                        end
                    end else begin
                        err_addr <= 1'b1;
                        if (wr_s) bus_q <= '0;
                    end
                end
                RAM_WAIT: begin
                    if (ram_byte_ready) begin
                        bus_q   <= ram_byte;
                        state   <= ACK;
                        EppWait <= 1'b1;
                    end else if (timer <= TW'(1)) begin
                        bus_q       <= 8'hFF;
                        err_timeout <= 1'b1;
                        state       <= ACK;
                        EppWait     <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ACK: begin
                    if (astb_s && dstb_s) begin
                        EppWait <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_regfile_v2.sv
// Directed bench for epp_regfile_v2 with hand-computed expectations.
module tb_epp_regfile_v2;
    import epp_pkg::*;

    localparam int NR   = 12;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          EppAstb, EppDstb, EppWR;
    wire           EppWait;
    wire  [7:0]    EppDB;
    logic [7:0]    db_drv;
    logic          db_oe;
    wire  [NR*8-1:0] regs_flat;
    wire           start_blit, start_fill, fill_value, start_read_ram, start_write_ram;
    wire  [7:0]    write_ram_byte;
    logic          status, ram_byte_ready;
    logic [7:0]    ram_byte;
    epp_state_t    dut_state;

    int n_pass = 0, n_total = 0;
    int n_blit = 0, n_fill = 0, n_rd = 0, n_wr = 0;

    assign EppDB = db_oe ? db_drv : 8'bz;

    epp_regfile_v2 #(.NUM_REGS(NR), .RAM_TIMEOUT(255), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst             (rst),
        .EppAstb         (EppAstb),
        .EppDstb         (EppDstb),
        .EppWR           (EppWR),
        .EppWait         (EppWait),
        .EppDB           (EppDB),
        .regs_flat       (regs_flat),
        .start_blit      (start_blit),
        .start_fill      (start_fill),
        .fill_value      (fill_value),
        .start_read_ram  (start_read_ram),
        .start_write_ram (start_write_ram),
        .write_ram_byte  (write_ram_byte),
        .status          (status),
        .ram_byte_ready  (ram_byte_ready),
        .ram_byte        (ram_byte),
        .state           (dut_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_blit === 1'b1)      n_blit <= n_blit + 1;
        if (start_fill === 1'b1)      n_fill <= n_fill + 1;
        if (start_read_ram === 1'b1)  n_rd   <= n_rd + 1;
        if (start_write_ram === 1'b1) n_wr   <= n_wr + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One host access; returns read data, strobe-to-Wait and release-to-unWait cycle counts.
    task automatic host(input bit is_addr, input bit is_write, input logic [7:0] wdata,
                        output logic [7:0] rdata, output int lat, output int rel);
        @(negedge clk);
        if (is_write) begin
            EppWR = 1'b0;
            repeat (SYNC + 2) @(negedge clk);
            db_drv = wdata;
            db_oe  = 1'b1;
        end else begin
            db_oe = 1'b0;
            EppWR = 1'b1;
            repeat (SYNC + 2) @(negedge clk);
        end
        if (is_addr) EppAstb = 1'b0;
        else         EppDstb = 1'b0;
        lat = 0;
        while (EppWait !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("wait_rise", EppWait, 1'b1);
        rdata   = EppDB;
        EppAstb = 1'b1;
        EppDstb = 1'b1;
        rel = 0;
        while (EppWait !== 1'b0 && rel < 100) begin
            @(negedge clk);
            rel++;
        end
        chk("wait_fall", EppWait, 1'b0);
        db_oe = 1'b0;
        EppWR = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]      rd;
        logic [NR*8-1:0] snap;
        int              lat, rel, w;

        rst = 1'b1; EppAstb = 1'b1; EppDstb = 1'b1; EppWR = 1'b1;
        db_oe = 1'b0; db_drv = '0; status = 1'b0; ram_byte_ready = 1'b0; ram_byte = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait", EppWait, 1'b0);
        chk("rst_regs", regs_flat, '0);
        chk("rst_state", dut_state, IDLE);
        chk("rst_bus", EppDB, 8'h00);
        chk("rst_wrbyte", write_ram_byte, 8'h00);

        // Basic register write and readback with handshake timing.
        host(1, 1, 8'h03, rd, lat, rel);
        host(0, 1, 8'hA5, rd, lat, rel);
        chk("wr_latency_le", (lat <= SYNC + 2), 1'b1);
        chk("wr_release", rel, SYNC + 1);
        chk("reg3", regs_flat[31:24], 8'hA5);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("rd_reg3", rd, 8'hA5);

        // Auto-increment with wrap from the last register to 0.
        host(1, 1, 8'd16, rd, lat, rel);
        host(0, 1, 8'h01, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("ctrl_rd", rd, 8'h01);
        host(1, 1, 8'd10, rd, lat, rel);
        host(0, 1, 8'h11, rd, lat, rel);
        host(0, 1, 8'h22, rd, lat, rel);
        host(0, 1, 8'h33, rd, lat, rel);
        chk("reg10", regs_flat[87:80], 8'h11);
        chk("reg11", regs_flat[95:88], 8'h22);
        chk("reg0_wrap", regs_flat[7:0], 8'h33);
        host(1, 0, 8'h00, rd, lat, rel);
        chk("addr_after_wrap", rd, 8'h01);
        host(1, 1, 8'd16, rd, lat, rel);
        host(0, 1, 8'h00, rd, lat, rel);

        // DMA read answered by the engine after 5 cycles.
        host(1, 1, 8'd14, rd, lat, rel);
        fork
            host(0, 0, 8'h00, rd, lat, rel);
            begin : responder
                int n;
                n = 0;
                while (start_read_ram !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(negedge clk);
                ram_byte = 8'h5C;
                ram_byte_ready = 1'b1;
                @(negedge clk);
                ram_byte_ready = 1'b0;
            end
        join
        chk("dma_rd", rd, 8'h5C);
        chk("dma_rd_pulses", n_rd, 1);

        // DMA read with no answer times out.
        host(0, 0, 8'h00, rd, lat, rel);
        chk("dma_timeout", rd, 8'hFF);
        chk("dma_rd_pulses2", n_rd, 2);
        host(1, 1, 8'd15, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("status_timeout", rd, 8'h08);

        // DMA while the engine is busy.
        status = 1'b1;
        host(1, 1, 8'd14, rd, lat, rel);
        host(0, 1, 8'h77, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("busy_rd", rd, 8'h00);
        chk("busy_no_wr", n_wr, 0);
        chk("busy_no_rd", n_rd, 2);
        chk("busy_wrbyte", write_ram_byte, 8'h00);
        host(1, 1, 8'd15, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("status_busy", rd, 8'h0D);
        status = 1'b0;
        host(1, 1, 8'd16, rd, lat, rel);
        host(0, 1, 8'h80, rd, lat, rel);
        host(1, 1, 8'd15, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("status_cleared", rd, 8'h00);

        // Normal DMA write and the two command pulses.
        host(1, 1, 8'd14, rd, lat, rel);
        host(0, 1, 8'h99, rd, lat, rel);
        chk("dma_wr_pulses", n_wr, 1);
        chk("dma_wrbyte", write_ram_byte, 8'h99);
        host(1, 1, 8'd12, rd, lat, rel);
        host(0, 1, 8'h00, rd, lat, rel);
        chk("blit_pulses", n_blit, 1);
        host(1, 1, 8'd13, rd, lat, rel);
        host(0, 1, 8'h01, rd, lat, rel);
        chk("fill_pulses", n_fill, 1);
        chk("fill_value", fill_value, 1'b1);

        // Invalid address.
        snap = regs_flat;
        host(1, 1, 8'h40, rd, lat, rel);
        host(0, 1, 8'h5A, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("inval_rd", rd, 8'h00);
        chk("inval_regs", regs_flat, snap);
        host(1, 1, 8'd15, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("status_err_addr", rd, 8'h02);

        // Reset while waiting on a DMA read; a late ready must be ignored.
        host(1, 1, 8'd14, rd, lat, rel);
        @(negedge clk);
        EppWR = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        EppDstb = 1'b0;
        w = 0;
        while (dut_state !== RAM_WAIT && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ram_wait", dut_state, RAM_WAIT);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        EppDstb = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ram_byte = 8'hEE;
        ram_byte_ready = 1'b1;
        @(negedge clk);
        ram_byte_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_wait", EppWait, 1'b0);
        chk("post_rst_state", dut_state, IDLE);
        chk("post_rst_regs", regs_flat, '0);
        chk("post_rst_bus", EppDB, 8'h00);
        host(1, 1, 8'd5, rd, lat, rel);
        host(0, 1, 8'h3C, rd, lat, rel);
        host(0, 0, 8'h00, rd, lat, rel);
        chk("post_rst_rd", rd, 8'h3C);
        chk("post_rst_reg5", regs_flat[47:40], 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
